// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath mux selects, ALU operations and immediate formats.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_EXEC_U   = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_SUB  = 2'b01,
        ALU_OP_FUNC = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_INVALID = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [2:0] imm_type_of(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: instruction fields and flags in, mux selects,
// write strobes and the memory request handshake out.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [6:0] op_code;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [2:0] imm_type;
    logic       illegal_instr;
    logic       mem_fault;

    modport master (
        input  op_code, func3, func7, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, imm_type,
               illegal_instr, mem_fault
    );

    modport slave (
        output op_code, func3, func7, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, imm_type,
               illegal_instr, mem_fault
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: the FSM picks add/sub directly or defers to func3.
// func7 is carried for a future ADD/SUB split and is not decoded yet.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] alu_control
);

    logic unused_func7_s;
    assign unused_func7_s = ^func7;

    // Map the FSM request and func3 onto an ALU operation.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (func3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_INVALID;
                endcase
            end
            default: alu_control = ALU_INVALID;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and guards memory waits with a watchdog.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             illegal_r;
    logic             fault_r;
    logic             timeout_s;
    logic             wait_inc_s;

    logic             mem_req_s;
    logic             mem_write_s;
    logic             adr_src_s;
    logic             ir_write_s;
    logic             pc_write_s;
    logic             reg_write_s;
    logic [1:0]       alu_src_a_s;
    logic [1:0]       alu_src_b_s;
    logic [1:0]       result_src_s;
    alu_op_t          alu_op_s;

    function automatic state_t decode_target(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_RTYPE:          nxt = S_EXEC_R;
            OP_ITYPE:          nxt = S_EXEC_I;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_LUI, OP_AUIPC:  nxt = S_EXEC_U;
            default:           nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // A ready arriving on the limit cycle still completes the access.
    assign timeout_s  = (TIMEOUT_CYCLES != 32'd0) && (wait_cnt_r == CNT_LIMIT) && !bus.mem_ready;
    assign wait_inc_s = mem_req_s && !bus.mem_ready && (wait_cnt_r != CNT_MAX);

    // State register, watchdog counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= '0;
            illegal_r  <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                wait_cnt_r <= '0;
            end else if (wait_inc_s) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
            if (next_state_s == S_ILLEGAL) begin
                illegal_r <= 1'b1;
            end
            if (next_state_s == S_FAULT) begin
                fault_r <= 1'b1;
            end
        end
    end

    // Next-state logic and Moore control decode.
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RS2;
        result_src_s = RES_ALUOUT;
        alu_op_s     = ALU_OP_ADD;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else if (timeout_s) begin
                    next_state_s = S_FAULT;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s  = SRC_A_OLDPC;
                alu_src_b_s  = SRC_B_IMM;
                next_state_s = decode_target(bus.op_code);
            end
            S_MEMADR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                if (bus.op_code[5]) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMREAD, S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = (state_r == S_MEMWRITE);
                adr_src_s   = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = (state_r == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                end else if (timeout_s) begin
                    next_state_s = S_FAULT;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_MEMWB: begin
                result_src_s = RES_RDATA;
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = (state_r == S_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                alu_op_s     = ALU_OP_FUNC;
                next_state_s = S_ALUWB;
            end
            S_EXEC_U: begin
                alu_src_b_s = SRC_B_IMM;
                if (bus.op_code[5]) begin
                    alu_src_a_s = SRC_A_ZERO;
                end else begin
                    alu_src_a_s = SRC_A_OLDPC;
                end
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_op_s     = ALU_OP_SUB;
                pc_write_s   = bus.zero;
                next_state_s = S_FETCH;
            end
            S_JAL: begin
                // Target already sits in alu_out; the ALU forms old_pc+4 for the link.
                alu_src_a_s  = SRC_A_OLDPC;
                alu_src_b_s  = SRC_B_FOUR;
                pc_write_s   = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_ILLEGAL: next_state_s = S_ILLEGAL;
            S_FAULT:   next_state_s = S_FAULT;
            default:   next_state_s = S_FAULT;
        endcase
    end

    multicycle_control_alu_decoder u_alu_decoder (
        .alu_op      (alu_op_s),
        .func3       (bus.func3),
        .func7       (bus.func7),
        .alu_control (bus.alu_control)
    );

    // Strobes and memory request are held low while reset is asserted.
    always_comb begin
        if (reset) begin
            bus.mem_req   = 1'b0;
            bus.mem_write = 1'b0;
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.reg_write = 1'b0;
        end else begin
            bus.mem_req   = mem_req_s;
            bus.mem_write = mem_write_s;
            bus.ir_write  = ir_write_s;
            bus.pc_write  = pc_write_s;
            bus.reg_write = reg_write_s;
        end
    end

    assign bus.adr_src       = adr_src_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.result_src    = result_src_s;
    assign bus.imm_type      = imm_type_of(bus.op_code);
    assign bus.illegal_instr = illegal_r;
    assign bus.mem_fault     = fault_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds each instruction's expected cycle script
// from the sequencing rules, then replays it with random inputs and compares.
module tb_multicycle_control;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus_if ();

    multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Output vector in port order; a/b/rs are the three mux selects.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [2:0] alu;
        logic [2:0] imm;
        logic       ill;
        logic       flt;
    } outv_t;

    typedef struct packed {
        logic  fixed;
        logic  rdy;
        logic  br;
        outv_t o;
    } cyc_t;

    cyc_t plan[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == 7'b0100011) return 3'd1;
        else if (op == 7'b1100011) return 3'd2;
        else if (op == 7'b1101111) return 3'd3;
        else if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;
        else return 3'd0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3);
        if (f3 == 3'b000) return 3'b000;
        else if (f3 == 3'b110) return 3'b011;
        else if (f3 == 3'b111) return 3'b010;
        else return 3'b111;
    endfunction

    function automatic outv_t blank(input logic [6:0] op);
        outv_t o;
        o = '0;
        o.imm = imm_of(op);
        return o;
    endfunction

    task automatic push(input outv_t o, input logic fixed, input logic rdy, input logic br);
        cyc_t c;
        c.fixed = fixed;
        c.rdy   = rdy;
        c.br    = br;
        c.o     = o;
        plan.push_back(c);
    endtask

    task automatic plan_access(input outv_t wt, input outv_t done, input int w, output bit dead);
        int nw;
        dead = (w > TMO);
        nw   = dead ? TMO + 1 : w;
        for (int i = 0; i < nw; i++) push(wt, 1'b1, 1'b0, 1'b0);
        if (!dead) push(done, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic plan_terminal(input outv_t o);
        for (int i = 0; i < 3; i++) push(o, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3,
                              input int wf, input int wm, output bit term);
        outv_t o, d;
        bit dead;
        plan.delete();
        term = 1'b0;
        o = blank(op); o.mem_req = 1'b1; o.b = 2'b10; o.rs = 2'b10;
        d = o; d.ir_write = 1'b1; d.pc_write = 1'b1;
        plan_access(o, d, wf, dead);
        if (dead) begin
            o = blank(op); o.flt = 1'b1; plan_terminal(o); term = 1'b1;
            return;
        end
        o = blank(op); o.a = 2'b01; o.b = 2'b01; push(o, 1'b0, 1'b0, 1'b0);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            o = blank(op); o.a = 2'b10; o.b = 2'b01; push(o, 1'b0, 1'b0, 1'b0);
            o = blank(op); o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = op[5];
            plan_access(o, o, wm, dead);
            if (dead) begin
                o = blank(op); o.flt = 1'b1; plan_terminal(o); term = 1'b1;
            end else if (!op[5]) begin
                o = blank(op); o.rs = 2'b01; o.reg_write = 1'b1; push(o, 1'b0, 1'b0, 1'b0);
            end
        end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 ||
                     op == 7'b0010111 || op == 7'b1101111) begin
            o = blank(op);
            if (op == 7'b1101111) begin
                o.a = 2'b01; o.b = 2'b10; o.pc_write = 1'b1;
            end else if (op[2]) begin
                o.b = 2'b01; o.a = op[5] ? 2'b11 : 2'b01;
            end else begin
                o.a = 2'b10; o.b = op[5] ? 2'b00 : 2'b01; o.alu = alu_of(f3);
            end
            push(o, 1'b0, 1'b0, 1'b0);
            o = blank(op); o.reg_write = 1'b1; push(o, 1'b0, 1'b0, 1'b0);
        end else if (op == 7'b1100011) begin
            o = blank(op); o.a = 2'b10; o.alu = 3'b001; push(o, 1'b0, 1'b0, 1'b1);
        end else begin
            o = blank(op); o.ill = 1'b1; plan_terminal(o); term = 1'b1;
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: model gives %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic run_plan(input logic [6:0] op, input logic [2:0] f3, input int limit, input string tag);
        outv_t exp_v, act_v;
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            @(negedge clk);
            reset            = 1'b0;
            bus_if.op_code   = op;
            bus_if.func3     = f3;
            bus_if.func7     = 7'($urandom);
            bus_if.zero      = 1'($urandom);
            bus_if.mem_ready = plan[i].fixed ? plan[i].rdy : 1'($urandom);
            #1;
            exp_v = plan[i].o;
            if (plan[i].br) exp_v.pc_write = bus_if.zero;
            act_v = {bus_if.mem_req, bus_if.mem_write, bus_if.adr_src, bus_if.ir_write,
                     bus_if.pc_write, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
                     bus_if.result_src, bus_if.alu_control, bus_if.imm_type,
                     bus_if.illegal_instr, bus_if.mem_fault};
            n_vec++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s op=%b cycle %0d: got %b, expected %b", tag, op, i, act_v, exp_v);
            end
        end
    endtask

    task automatic do_reset();
        logic [6:0] got;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset            = 1'b1;
            bus_if.mem_ready = 1'($urandom);
            #1;
            got = {bus_if.mem_req, bus_if.mem_write, bus_if.ir_write, bus_if.pc_write,
                   bus_if.reg_write, bus_if.illegal_instr, bus_if.mem_fault};
            if (k == 0) got[1:0] = 2'b00;
            n_vec++;
            if (got !== 7'b0) begin
                n_bad++;
                $display("FAIL reset_strobes cycle %0d: got %b, expected 0000000", k, got);
            end
        end
    endtask

    task automatic one(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                       input string tag);
        bit term;
        plan_instr(op, f3, wf, wm, term);
        run_plan(op, f3, 1000, tag);
        if (term) do_reset();
    endtask

    logic [6:0] ops [10];
    bit         t;

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111};
        reset            = 1'b1;
        bus_if.op_code   = 7'b0000011;
        bus_if.func3     = 3'b000;
        bus_if.func7     = 7'b0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;
        do_reset();

        plan_instr(7'b0000011, 3'b010, 0, 0, t);
        pin("lw_len", plan.size(), 5);
        pin("lw_wb_cycle5", int'(plan[4].o.reg_write), 1);
        run_plan(7'b0000011, 3'b010, 1000, "lw");

        plan_instr(7'b0100011, 3'b010, 0, 3, t);
        pin("sw_len", plan.size(), 7);
        run_plan(7'b0100011, 3'b010, 1000, "sw_wait3");

        plan_instr(7'b1100011, 3'b000, 0, 0, t);
        pin("beq_len", plan.size(), 3);
        pin("beq_alu", int'(plan[2].o.alu), 1);
        run_plan(7'b1100011, 3'b000, 1000, "beq");

        plan_instr(7'b0110011, 3'b110, 0, 0, t);
        pin("r_len", plan.size(), 4);
        pin("r_or_alu", int'(plan[2].o.alu), 3);
        run_plan(7'b0110011, 3'b110, 1000, "r_or");

        plan_instr(7'b1101111, 3'b000, 0, 0, t);
        pin("jal_len", plan.size(), 4);
        run_plan(7'b1101111, 3'b000, 1000, "jal");

        one(7'b1100011, 3'b000, 1, 0, "beq2");
        one(7'b0110011, 3'b111, 0, 0, "r_and");
        one(7'b0110011, 3'b001, 0, 0, "r_inv");
        one(7'b0110111, 3'b000, 0, 0, "lui");
        one(7'b0010111, 3'b000, 0, 0, "auipc");
        one(7'b0010011, 3'b000, 2, 0, "addi");
        one(7'b1110011, 3'b000, 0, 0, "illegal");

        plan_instr(7'b0000011, 3'b000, 5, 0, t);
        pin("fetch_fault_len", plan.size(), 8);
        run_plan(7'b0000011, 3'b000, 1000, "fetch_fault");
        do_reset();

        plan_instr(7'b0000011, 3'b000, 4, 4, t);
        pin("limit_ready_len", plan.size(), 13);
        run_plan(7'b0000011, 3'b000, 1000, "limit_ready");
        one(7'b0000011, 3'b000, 0, 6, "memread_fault");

        plan_instr(7'b0100011, 3'b000, 0, 3, t);
        run_plan(7'b0100011, 3'b000, 4, "sw_cut");
        do_reset();
        one(7'b0110011, 3'b000, 0, 0, "after_cut");

        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            int wf, wm;
            op = ops[$urandom_range(0, 9)];
            wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 2));
            wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            one(op, 3'($urandom), wf, wm, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
